// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: write/read handshake bundle between a producer/consumer (master) and sync_fifo_param (slave)
interface sync_fifo_param_if #(
  parameter int WIDTH     = 8,
  parameter int PTR_WIDTH = 4
);
  logic                 wr_en_i;
  logic [WIDTH-1:0]     wdata_i;
  logic                 full_o;
  logic                 almost_full_o;
  logic                 wr_error_o;
  logic                 rd_en_i;
  logic [WIDTH-1:0]     r_data_o;
  logic                 rd_valid_o;
  logic                 empty_o;
  logic                 almost_empty_o;
  logic                 rd_error_o;
  logic [PTR_WIDTH:0]   count_o;
  modport master (
    output wr_en_i, wdata_i, rd_en_i,
    input  full_o, almost_full_o, wr_error_o, r_data_o, rd_valid_o,
           empty_o, almost_empty_o, rd_error_o, count_o
  );
  modport slave (
    input  wr_en_i, wdata_i, rd_en_i,
    output full_o, almost_full_o, wr_error_o, r_data_o, rd_valid_o,
           empty_o, almost_empty_o, rd_error_o, count_o
  );
endinterface

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with occupancy count, threshold flags and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through reads; default is one-cycle registered reads.
module sync_fifo_param #(
  parameter int WIDTH     = 8,
  parameter int PTR_WIDTH = 4,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 2
) (
  input logic               clk_i,
  input logic               rst_n_i,
  sync_fifo_param_if.slave  bus
);
  localparam int CW = PTR_WIDTH + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C   = CW'(AE_THRESH);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [PTR_WIDTH-1:0] P_ONE = PTR_WIDTH'(1);
  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]        cnt_nxt;
  logic                 rd_acc, wr_acc;
  // a read on a full FIFO frees the slot the simultaneous write lands in
  always_comb begin
    rd_acc  = bus.rd_en_i & ~bus.empty_o;
    wr_acc  = bus.wr_en_i & (~bus.full_o | rd_acc);
    cnt_nxt = (wr_acc & ~rd_acc) ? bus.count_o + C_ONE :
              (rd_acc & ~wr_acc) ? bus.count_o - C_ONE : bus.count_o;
  end
  always_ff @(posedge clk_i)
    if (rst_n_i && wr_acc) mem[wr_ptr] <= bus.wdata_i;
  // flags are computed from the next count so they align with count_o
  always_ff @(posedge clk_i)
    if (!rst_n_i) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      bus.count_o        <= '0;
      bus.empty_o        <= 1'b1;
      bus.almost_empty_o <= 1'b1;
      bus.full_o         <= 1'b0;
      bus.almost_full_o  <= 1'b0;
      bus.wr_error_o     <= 1'b0;
      bus.rd_error_o     <= 1'b0;
    end else begin
      wr_ptr             <= wr_acc ? wr_ptr + P_ONE : wr_ptr;
      rd_ptr             <= rd_acc ? rd_ptr + P_ONE : rd_ptr;
      bus.count_o        <= cnt_nxt;
      bus.empty_o        <= cnt_nxt == '0;
      bus.almost_empty_o <= cnt_nxt <= AE_C;
      bus.full_o         <= cnt_nxt == FULL_C;
      bus.almost_full_o  <= cnt_nxt >= AF_C;
      bus.wr_error_o     <= bus.wr_en_i & ~wr_acc;
      bus.rd_error_o     <= bus.rd_en_i & ~rd_acc;
    end
`ifdef SYNC_FIFO_FWFT_EN
  assign bus.r_data_o   = mem[rd_ptr];
  assign bus.rd_valid_o = ~bus.empty_o;
`else
  always_ff @(posedge clk_i)
    if (!rst_n_i) begin
      bus.r_data_o   <= '0;
      bus.rd_valid_o <= 1'b0;
    end else begin
      bus.r_data_o   <= rd_acc ? mem[rd_ptr] : bus.r_data_o;
      bus.rd_valid_o <= rd_acc;
    end
`endif
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: randomized self-checking bench for sync_fifo_param against a queue-based reference model.
// Works in both the default and SYNC_FIFO_FWFT_EN builds.
module tb_sync_fifo_param;
  localparam int WIDTH = 8, PTR_WIDTH = 4, DEPTH = 16, AF = 12, AE = 2;
  logic clk_i = 1'b0;
  logic rst_n_i = 1'b0;
  int n_chk = 0, n_fail = 0;
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] last_data = '0;
  sync_fifo_param_if #(.WIDTH(WIDTH), .PTR_WIDTH(PTR_WIDTH)) bus ();
  sync_fifo_param #(.WIDTH(WIDTH), .PTR_WIDTH(PTR_WIDTH), .DEPTH(DEPTH),
                    .AF_THRESH(AF), .AE_THRESH(AE))
    dut (.clk_i(clk_i), .rst_n_i(rst_n_i), .bus(bus));
  always #5 clk_i = ~clk_i;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_state(input logic exp_werr, input logic exp_rerr, input logic exp_valid);
    int n;
    n = q.size();
    check("count", 32'(bus.count_o), n);
    check("empty", 32'(bus.empty_o), 32'(n == 0));
    check("full", 32'(bus.full_o), 32'(n == DEPTH));
    check("almost_full", 32'(bus.almost_full_o), 32'(n >= AF));
    check("almost_empty", 32'(bus.almost_empty_o), 32'(n <= AE));
    check("wr_error", 32'(bus.wr_error_o), 32'(exp_werr));
    check("rd_error", 32'(bus.rd_error_o), 32'(exp_rerr));
`ifdef SYNC_FIFO_FWFT_EN
    check("rd_valid", 32'(bus.rd_valid_o), 32'(n != 0));
    if (n != 0) check("head_data", 32'(bus.r_data_o), 32'(q[0]));
`else
    check("rd_valid", 32'(bus.rd_valid_o), 32'(exp_valid));
    check("r_data", 32'(bus.r_data_o), 32'(last_data));
`endif
  endtask
  // called at a negedge; applies one cycle of requests and checks the result
  task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic r);
    logic ra, wa, ev;
    bus.wr_en_i = w;
    bus.wdata_i = d;
    bus.rd_en_i = r;
    ra = r && q.size() != 0;
    wa = w && (q.size() != DEPTH || ra);
    ev = 1'b0;
    if (ra) begin
      last_data = q.pop_front();
      ev = 1'b1;
    end
    if (wa) q.push_back(d);
    @(posedge clk_i);
    #1;
    check_state(w && !wa, r && !ra, ev);
    @(negedge clk_i);
    bus.wr_en_i = 1'b0;
    bus.rd_en_i = 1'b0;
  endtask
  task automatic do_reset();
    rst_n_i = 1'b0;
    bus.wr_en_i = 1'($urandom);
    bus.rd_en_i = 1'($urandom);
    bus.wdata_i = WIDTH'($urandom);
    @(posedge clk_i);
    #1;
    q.delete();
    last_data = '0;
    check_state(1'b0, 1'b0, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
`else
    check("reset_r_data", 32'(bus.r_data_o), 32'h0);
`endif
    @(negedge clk_i);
    rst_n_i = 1'b1;
    bus.wr_en_i = 1'b0;
    bus.rd_en_i = 1'b0;
  endtask
  initial begin
    logic w, r;
    bus.wr_en_i = 1'b0;
    bus.rd_en_i = 1'b0;
    bus.wdata_i = '0;
    @(negedge clk_i);
    do_reset();
    for (int i = 1; i <= DEPTH; i++) step(1'b1, WIDTH'(i), 1'b0);
    step(1'b1, 8'h77, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b1, WIDTH'($urandom), 1'b0);
    step(1'b1, 8'hAA, 1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h55, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, WIDTH'($urandom), 1'b0);
    for (int i = 0; i < 200; i++) begin
      w = 1'($urandom);
      r = 1'($urandom);
      if (q.size() == 1 && r && !w) r = 1'b0;
      if (q.size() == DEPTH - 1 && w && !r) w = 1'b0;
      step(w, WIDTH'($urandom), r);
    end
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 99) < 55), WIDTH'($urandom), 1'($urandom_range(0, 99) < 45));
    while (q.size() < 9) step(1'b1, WIDTH'($urandom), 1'b0);
    while (q.size() > 9) step(1'b0, 8'h00, 1'b1);
    do_reset();
    step(1'b1, 8'h3C, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
